i2c_cfg_seq: RTL
================

I2C_CFG_SEQ -- requirements
Module: i2c_cfg_seq

Interface
REQ-001 SHALL have parameter I2C_BASEADDR, default 0: bus base address of the downstream i2c peripheral.
REQ-002 SHALL have parameter N_ENTRIES, default 8: number of configuration table entries (1..256).
REQ-003 SHALL have parameter GAP_CYCLES, default 16: idle clocks between consecutive transactions.
REQ-004 SHALL have parameter POLL_LIMIT, default 4096: maximum status polls per transaction before timeout.
REQ-005 SHALL have port clk  in  1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-007 SHALL have port start  in  1: one-cycle pulse that begins the table walk.
REQ-008 SHALL have port busy  out  1: high from the accepted start until DONE or FAIL.
REQ-009 SHALL have port done  out  1: sticky; high after the table completes without error.
REQ-010 SHALL have port error  out  1: sticky; high after a NACK or a timeout.
REQ-011 SHALL have port err_index  out  8: index of the table entry that failed.
REQ-012 SHALL have port address  out  8: bus address to the i2c peripheral.
REQ-013 SHALL have port data  inout  8: bidirectional bus data; driven only while wr=1, otherwise high-Z.
REQ-014 SHALL have ports rd  out  1 and wr  out  1: one-cycle bus strobes.

Function
REQ-015 SHALL store each table entry as 24 bits {dev[7:0], reg[7:0], val[7:0]}; dev=8'hFF marks end of table and terminates the walk early with done.
REQ-016 SHALL use the states IDLE, FETCH, W_CMD, W_DEV, W_REG, W_VAL, POLL, CHECK, GAP, DONE, FAIL.
REQ-017 SHALL accept start only in IDLE, DONE or FAIL, clear done, error and err_index, set index=0 and enter FETCH; start in any other state SHALL be ignored.
REQ-018 SHALL read the table registered in FETCH with one cycle of latency, then enter W_CMD, or DONE if dev=8'hFF.
REQ-019 SHALL perform each bus write as wr=1 for one cycle with address=I2C_BASEADDR+1 and data driven, followed by one cycle with wr=0, address=0 and data high-Z.
REQ-020 SHALL write, in order: 8'h82 (W_CMD), dev (W_DEV), reg (W_REG), val (W_VAL).
REQ-021 SHALL, in POLL, assert rd=1 for one cycle with address=I2C_BASEADDR+0 and capture data on the edge that ends that cycle; bit0 is busy and bit1 is nack.
REQ-022 SHALL, in CHECK: go to FAIL on nack=1; return to POLL on busy=1 while polls<POLL_LIMIT; go to FAIL on busy=1 when polls=POLL_LIMIT; go to GAP otherwise.
REQ-023 SHALL wait exactly GAP_CYCLES clocks in GAP, then increment index; it SHALL enter DONE if index wraps to N_ENTRIES, else FETCH.
REQ-024 SHALL, in FAIL, latch err_index=index and set error=1; in DONE it SHALL set done=1; both states SHALL hold bus outputs idle.
REQ-025 SHALL never assert rd and wr in the same cycle.
REQ-026 SHALL size the poll counter for POLL_LIMIT, saturate it, and clear it on entry to each W_CMD.

Reset
REQ-027 SHALL, on reset=1 at a clock edge, enter IDLE from any state (including mid-write or mid-poll) and set busy=0, done=0, error=0, err_index=0, rd=0, wr=0, address=0, data high-Z.
REQ-028 SHALL require no reset of the table storage.

Structure
REQ-029 SHALL place the entry field widths, the end marker 8'hFF, the command byte 8'h82, the status bit positions and the state encoding in shared package i2c_cfg_pkg.
REQ-030 SHALL hold the table in sub-module i2c_cfg_rom (registered read, index in, 24-bit entry out); the sequencer FSM SHALL stay in i2c_cfg_seq.

Verification
REQ-031 SHALL verify: table entry 0 = {AA,32,11}, start -> writes (1,82),(1,AA),(1,32),(1,11) with 2-cycle spacing, then rd at address 0.
REQ-032 SHALL verify: status busy for 10 polls, then 0 -> exactly GAP_CYCLES idle clocks, then entry 1 fetched; done=1 after entry N_ENTRIES-1.
REQ-033 SHALL verify: entry 2 dev=FF -> done=1 after entry 1 completes, with no further bus activity.
REQ-034 SHALL verify: status 8'h02 on entry 3 -> error=1, err_index=3, busy=0, bus idle.
REQ-035 SHALL verify: status stuck at 8'h01 with POLL_LIMIT=4 -> FAIL after 5 polls, error=1.
REQ-036 SHALL verify: reset asserted during W_REG -> next cycle IDLE with all outputs at reset values; a second start mid-walk is ignored.

Source files
------------

// File: rtl/i2c_cfg_pkg.sv
// i2c_cfg_pkg: shared definitions for the I2C configuration sequencer.
// Holds the table entry layout, the end-of-table marker, the command byte
// written ahead of every entry, the status bit positions returned by the
// downstream peripheral and the sequencer state encoding.
package i2c_cfg_pkg;

  localparam int FIELD_W = 8;
  localparam int ENTRY_W = 3 * FIELD_W;

  localparam logic [FIELD_W-1:0] END_MARK = 8'hFF;
  localparam logic [FIELD_W-1:0] CMD_BYTE = 8'h82;

  // Status byte returned by a peripheral read.
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_NACK_BIT = 1;

  typedef struct packed {
    logic [FIELD_W-1:0] dev;
    logic [FIELD_W-1:0] reg_addr;
    logic [FIELD_W-1:0] val;
  } entry_t;

  // Filler for unused table slots; reads as an immediate end of table.
  localparam logic [ENTRY_W-1:0] END_ENTRY = {END_MARK, {(2*FIELD_W){1'b0}}};

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    W_CMD,
    W_DEV,
    W_REG,
    W_VAL,
    POLL,
    CHECK,
    GAP,
    DONE,
    FAIL
  } state_e;

  function automatic logic is_end(input entry_t e);
    return e.dev == END_MARK;
  endfunction

endpackage

// File: rtl/i2c_cfg_rom.sv
// i2c_cfg_rom: configuration table with a registered read port.
// Contents come from the TABLE parameter (entry i at bits [i*24 +: 24]);
// slots at or beyond N_ENTRIES read back as an end-of-table marker.
// Ports:
//   clk    - clock
//   index  - entry index to read
//   entry  - entry at index, valid one clock after index is presented
module i2c_cfg_rom
  import i2c_cfg_pkg::*;
#(
  parameter int                           N_ENTRIES = 8,
  parameter logic [N_ENTRIES*ENTRY_W-1:0] TABLE     = {N_ENTRIES{END_ENTRY}}
) (
  input  logic       clk,
  input  logic [7:0] index,
  output entry_t     entry
);

  // Full 256-slot view so any 8-bit index is a legal lookup.
  entry_t mem [256];

  for (genvar i = 0; i < 256; i++) begin : g_mem
    if (i < N_ENTRIES) begin : g_used
      assign mem[i] = TABLE[i*ENTRY_W +: ENTRY_W];
    end else begin : g_pad
      assign mem[i] = END_ENTRY;
    end
  end

  always_ff @(posedge clk) begin
    entry <= mem[index];
  end

endmodule

// File: rtl/i2c_cfg_seq.sv
// i2c_cfg_seq: walks a configuration table and programs each entry into an
// I2C peripheral over a simple register bus. Per entry it writes the command
// byte, device, register and value to the data register (base+1), then polls
// the status register (base+0) until the transfer completes, NACKs or the
// poll budget runs out, and finally idles GAP_CYCLES clocks.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   start           - one-cycle pulse, accepted in IDLE/DONE/FAIL
//   busy            - walk in progress
//   done / error    - sticky completion / failure flags
//   err_index       - entry index that failed
//   address         - bus address
//   data            - bidirectional bus data, driven only while wr=1
//   rd / wr         - one-cycle bus strobes
module i2c_cfg_seq
  import i2c_cfg_pkg::*;
#(
  parameter int                           I2C_BASEADDR = 0,
  parameter int                           N_ENTRIES    = 8,
  parameter int                           GAP_CYCLES   = 16,
  parameter int                           POLL_LIMIT   = 4096,
  parameter logic [N_ENTRIES*ENTRY_W-1:0] TABLE        = {N_ENTRIES{END_ENTRY}}
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] err_index,
  output logic [7:0] address,
  inout  wire  [7:0] data,
  output logic       rd,
  output logic       wr
);

  localparam int PW = $clog2(POLL_LIMIT + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [7:0]    ADDR_STAT = 8'(I2C_BASEADDR);
  localparam logic [7:0]    ADDR_DATA = 8'(I2C_BASEADDR + 1);
  localparam logic [PW-1:0] POLL_MAX  = PW'(POLL_LIMIT);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [8:0]    LAST_IDX  = 9'(N_ENTRIES - 1);

  state_e        state, state_n;
  logic          phase, phase_n;
  logic [7:0]    index;
  logic [PW-1:0] polls;
  logic [GW-1:0] gap_cnt;
  logic          stat_busy, stat_nack;
  entry_t        entry;
  logic [7:0]    wr_data;

  logic start_acc, poll_clr, poll_inc, gap_clr, gap_inc, idx_adv, set_done, set_err;
  logic last_entry, gap_end;

  i2c_cfg_rom #(
    .N_ENTRIES (N_ENTRIES),
    .TABLE     (TABLE)
  ) u_rom (
    .clk   (clk),
    .index (index),
    .entry (entry)
  );

  assign last_entry = ({1'b0, index} == LAST_IDX);
  assign gap_end    = (GAP_CYCLES == 0) || (gap_cnt == GAP_LAST);

  // Next state. FETCH and every W_* state take two clocks, tracked by phase:
  // FETCH waits for the registered table read, W_* splits the strobe cycle
  // from the idle bus cycle that follows it.
  always_comb begin
    state_n   = state;
    phase_n   = 1'b0;
    start_acc = 1'b0;
    poll_clr  = 1'b0;
    poll_inc  = 1'b0;
    gap_clr   = 1'b0;
    gap_inc   = 1'b0;
    idx_adv   = 1'b0;
    set_done  = 1'b0;
    set_err   = 1'b0;
    case (state)
      IDLE, DONE, FAIL: begin
        if (start) begin
          start_acc = 1'b1;
          state_n   = FETCH;
        end
      end
      FETCH: begin
        if (!phase) begin
          phase_n = 1'b1;
        end else if (is_end(entry)) begin
          state_n  = DONE;
          set_done = 1'b1;
        end else begin
          state_n  = W_CMD;
          poll_clr = 1'b1;
        end
      end
      W_CMD: begin
        if (!phase) phase_n = 1'b1;
        else        state_n = W_DEV;
      end
      W_DEV: begin
        if (!phase) phase_n = 1'b1;
        else        state_n = W_REG;
      end
      W_REG: begin
        if (!phase) phase_n = 1'b1;
        else        state_n = W_VAL;
      end
      W_VAL: begin
        if (!phase) phase_n = 1'b1;
        else        state_n = POLL;
      end
      POLL: state_n = CHECK;
      // polls counts re-polls already granted, so a stuck-busy peripheral
      // sees POLL_LIMIT+1 reads before the transaction is abandoned.
      CHECK: begin
        if (stat_nack) begin
          state_n = FAIL;
          set_err = 1'b1;
        end else if (stat_busy) begin
          if (polls < POLL_MAX) begin
            state_n  = POLL;
            poll_inc = 1'b1;
          end else begin
            state_n = FAIL;
            set_err = 1'b1;
          end
        end else if (GAP_CYCLES == 0) begin
          idx_adv  = 1'b1;
          state_n  = last_entry ? DONE : FETCH;
          set_done = last_entry;
        end else begin
          state_n = GAP;
          gap_clr = 1'b1;
        end
      end
      GAP: begin
        if (gap_end) begin
          idx_adv  = 1'b1;
          state_n  = last_entry ? DONE : FETCH;
          set_done = last_entry;
        end else begin
          gap_inc = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Bus outputs decode straight from the state register.
  always_comb begin
    rd      = 1'b0;
    wr      = 1'b0;
    address = 8'h00;
    wr_data = 8'h00;
    case (state)
      W_CMD: begin wr = !phase; wr_data = CMD_BYTE;       end
      W_DEV: begin wr = !phase; wr_data = entry.dev;      end
      W_REG: begin wr = !phase; wr_data = entry.reg_addr; end
      W_VAL: begin wr = !phase; wr_data = entry.val;      end
      POLL:  rd = 1'b1;
      default: ;
    endcase
    if (wr)      address = ADDR_DATA;
    else if (rd) address = ADDR_STAT;
  end

  always_comb begin
    busy = !(state inside {IDLE, DONE, FAIL});
  end

  assign data = wr ? wr_data : 8'bzzzz_zzzz;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_index <= 8'h00;
      index     <= 8'h00;
      polls     <= '0;
      gap_cnt   <= '0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      if (start_acc) begin
        done      <= 1'b0;
        error     <= 1'b0;
        err_index <= 8'h00;
        index     <= 8'h00;
      end
      if (set_done) done <= 1'b1;
      if (set_err) begin
        error     <= 1'b1;
        err_index <= index;
      end
      if (idx_adv) index <= index + 8'd1;
      if (poll_clr)                           polls <= '0;
      else if (poll_inc && polls != POLL_MAX) polls <= polls + 1'b1;
      if (gap_clr)      gap_cnt <= '0;
      else if (gap_inc) gap_cnt <= gap_cnt + 1'b1;
    end
  end

  // Status is sampled on the edge that closes the read strobe cycle.
  always_ff @(posedge clk) begin
    if (state == POLL) begin
      stat_busy <= data[STAT_BUSY_BIT];
      stat_nack <= data[STAT_NACK_BIT];
    end
  end

endmodule
